// File: rtl/utim_comparator_array.sv
// utim_comparator_array
// Bank of P_CH compare/match channels watching the shared main counter.
// Each channel holds a reload interval (ini) and a live compare value (cmp).
// A match either advances cmp by ini (periodic) or disables the channel
// (one-shot). Matches with IRQ enabled set a sticky pending flag that only
// an acknowledge, a count write or an IRQ-disabling config write clears.
//
// Strobe semantics: iCONF_WRITE, iCOUNT_WRITE and iIRQ_ACK are single-cycle
// qualifiers sampled on the rising edge of iCLOCK. The block is always ready,
// so there is no backpressure, and a strobe that targets a channel index
// >= P_CH has no effect.
module utim_comparator_array #(
    parameter int P_CH    = 4,
    parameter int P_WIDTH = 64,
    parameter int P_CHW   = 2
)(
    input  logic               iCLOCK,
    input  logic               inRESET,
    input  logic               iMTIMER_WORKING,
    input  logic [P_WIDTH-1:0] iMTIMER_COUNT,
    input  logic               iCONF_WRITE,
    input  logic [P_CHW-1:0]   iCONF_CH,
    input  logic               iCONF_ENA,
    input  logic               iCONF_IRQENA,
    input  logic               iCONF_FULLMODE,
    input  logic               iCONF_PERIODIC,
    input  logic               iCOUNT_WRITE,
    input  logic [P_CHW-1:0]   iCOUNT_CH,
    input  logic [1:0]         inCOUNT_DQM,
    input  logic [P_WIDTH-1:0] iCOUNT_COUNTER,
    input  logic               iIRQ_ACK,
    input  logic [P_CH-1:0]    iIRQ_ACK_MASK,
    output logic [P_CH-1:0]    oIRQ,
    output logic               oIRQ_ANY
);
    localparam int HALF = P_WIDTH / 2;

    // Architectural state
    logic [P_CH-1:0]    ena;
    logic [P_CH-1:0]    irqEna;
    logic [P_CH-1:0]    fullMode;
    logic [P_CH-1:0]    periodic;
    logic [P_WIDTH-1:0] ini [P_CH];
    logic [P_WIDTH-1:0] cmp [P_CH];
    logic [P_CH-1:0]    pending;
    logic               irqAny;

    // Combinational helpers
    logic [P_CH-1:0]    confSel;
    logic [P_CH-1:0]    countSel;
    logic [P_CH-1:0]    iniNonZero;
    logic [P_CH-1:0]    cmpEqual;
    logic [P_CH-1:0]    match;
    logic [P_CH-1:0]    enaNext;
    logic [P_CH-1:0]    irqEnaNext;
    logic [P_CH-1:0]    fullModeNext;
    logic [P_CH-1:0]    periodicNext;
    logic [P_CH-1:0]    pendingNext;
    logic [P_WIDTH-1:0] iniNext [P_CH];
    logic [P_WIDTH-1:0] cmpNext [P_CH];

    // Decode write strobes into per-channel selects; out-of-range indices select nothing.
    always_comb begin
        confSel  = '0;
        countSel = '0;
        for (int k = 0; k < P_CH; k++) begin
            confSel[k]  = iCONF_WRITE  && (int'(iCONF_CH)  == k);
            countSel[k] = iCOUNT_WRITE && (int'(iCOUNT_CH) == k);
        end
    end

    // Match detection from current-cycle state only; half mode ignores the high half entirely.
    always_comb begin
        iniNonZero = '0;
        cmpEqual   = '0;
        match      = '0;
        for (int k = 0; k < P_CH; k++) begin
            if (fullMode[k]) begin
                iniNonZero[k] = (ini[k] != '0);
                cmpEqual[k]   = (cmp[k] == iMTIMER_COUNT);
            end else begin
                iniNonZero[k] = (ini[k][HALF-1:0] != '0);
                cmpEqual[k]   = (cmp[k][HALF-1:0] == iMTIMER_COUNT[HALF-1:0]);
            end
            match[k] = ena[k] & iMTIMER_WORKING & iniNonZero[k] & cmpEqual[k];
        end
    end

    // Next-state: match side effects first, then host writes override, pending set wins over clears.
    always_comb begin
        enaNext      = ena;
        irqEnaNext   = irqEna;
        fullModeNext = fullMode;
        periodicNext = periodic;
        pendingNext  = pending;
        for (int k = 0; k < P_CH; k++) begin
            iniNext[k] = ini[k];
            cmpNext[k] = cmp[k];

            // A count write in the same cycle suppresses reload/disable for that channel.
            if (match[k] && !countSel[k]) begin
                if (periodic[k]) begin
                    // Full-width add so the low half carries into the high half in both modes.
                    cmpNext[k] = cmp[k] + ini[k];
                end else begin
                    enaNext[k] = 1'b0;
                end
            end

            if (confSel[k]) begin
                enaNext[k]      = iCONF_ENA;
                irqEnaNext[k]   = iCONF_IRQENA;
                fullModeNext[k] = iCONF_FULLMODE;
                periodicNext[k] = iCONF_PERIODIC;
            end

            if (countSel[k]) begin
                // Unmasked half loads both ini and cmp; masked half re-arms cmp from current ini.
                if (!inCOUNT_DQM[0]) begin
                    iniNext[k][HALF-1:0] = iCOUNT_COUNTER[HALF-1:0];
                    cmpNext[k][HALF-1:0] = iCOUNT_COUNTER[HALF-1:0];
                end else begin
                    cmpNext[k][HALF-1:0] = ini[k][HALF-1:0];
                end
                if (!inCOUNT_DQM[1]) begin
                    iniNext[k][P_WIDTH-1:HALF] = iCOUNT_COUNTER[P_WIDTH-1:HALF];
                    cmpNext[k][P_WIDTH-1:HALF] = iCOUNT_COUNTER[P_WIDTH-1:HALF];
                end else begin
                    cmpNext[k][P_WIDTH-1:HALF] = ini[k][P_WIDTH-1:HALF];
                end
            end

            if (countSel[k] || (confSel[k] && !iCONF_IRQENA) ||
                (iIRQ_ACK && iIRQ_ACK_MASK[k])) begin
                pendingNext[k] = 1'b0;
            end
            if (match[k] && irqEna[k]) begin
                pendingNext[k] = 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge iCLOCK) begin
        if (!inRESET) begin
            ena      <= '0;
            irqEna   <= '0;
            fullMode <= '0;
            periodic <= '0;
            pending  <= '0;
            irqAny   <= 1'b0;
            for (int k = 0; k < P_CH; k++) begin
                ini[k] <= '0;
                cmp[k] <= '0;
            end
        end else begin
            ena      <= enaNext;
            irqEna   <= irqEnaNext;
            fullMode <= fullModeNext;
            periodic <= periodicNext;
            pending  <= pendingNext;
            irqAny   <= |pendingNext;
            for (int k = 0; k < P_CH; k++) begin
                ini[k] <= iniNext[k];
                cmp[k] <= cmpNext[k];
            end
        end
    end

    assign oIRQ     = pending;
    assign oIRQ_ANY = irqAny;

endmodule
